// File: rtl/ksa_pkg.sv
`default_nettype none
// =============================================================================
// Module : ksa_pkg
// Shared types and helpers for the pipelined Kogge-Stone adder.
// Rev    : 1.0
// =============================================================================
package ksa_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int levels(input int width);
    return (width < 2) ? 1 : clog2(width);
  endfunction

  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    return pg_t'{hi.p & lo.p, hi.g | (hi.p & lo.g)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_pipe_reg.sv
`default_nettype none
// =============================================================================
// Module : ksa_pipe_reg
// WIDTH-wide pg_t register slice plus XW side bits with stall-propagating valid/ready.
// Rev    : 1.0
// =============================================================================
module ksa_pipe_reg
  import ksa_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int XW       = 1,
  parameter bit DATA_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  pg_t  [WIDTH-1:0] pg_i,
  input  logic [XW-1:0]    x_i,
  output logic             valid_o,
  input  logic             ready_i,
  output pg_t  [WIDTH-1:0] pg_o,
  output logic [XW-1:0]    x_o
);

  logic             valid_q;
  pg_t  [WIDTH-1:0] pg_q;
  logic [XW-1:0]    x_q;
  logic             load;

  assign ready_o = !valid_q || ready_i;
  assign load    = valid_i && ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
    end
  end

  // Only the output slice needs a defined data value out of reset.
  if (DATA_RST) begin : g_data_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pg_q <= '0;
        x_q  <= '0;
      end else if (load) begin
        pg_q <= pg_i;
        x_q  <= x_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      if (load) begin
        pg_q <= pg_i;
        x_q  <= x_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign pg_o    = pg_q;
  assign x_o     = x_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_ks_adder.sv
`default_nettype none
// =============================================================================
// Module : pipelined_ks_adder
// Parametrised pipelined Kogge-Stone adder with valid/ready; KSA_OVF_EN adds ovf.
// Rev    : 1.0
// =============================================================================
module pipelined_ks_adder
  import ksa_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter logic [31:0] STAGE_MASK = 32'b0101,
  parameter bit          IN_REG     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L  = levels(WIDTH);
  localparam int XW = WIDTH + 1;  // original propagate vector plus cin
`ifdef KSA_OVF_EN
  localparam int OXW = 2;
`else
  localparam int OXW = 1;
`endif

  pg_t  [WIDTH-1:0] lvl_pg [0:L];
  logic [XW-1:0]    lvl_x  [0:L];
  logic             lvl_v  [0:L];
  logic             lvl_r  [0:L];

  // Input slice reuses pg_t fields as raw operand bits: .p = a_i, .g = b_i.
  pg_t  [WIDTH-1:0] ab_d;
  pg_t  [WIDTH-1:0] ab_q;
  logic             cin_q;
  logic             in_v;
  logic             in_r;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) ab_d[i] = pg_t'{a[i], b[i]};
  end

  if (IN_REG) begin : g_in_reg
    ksa_pipe_reg #(.WIDTH(WIDTH), .XW(1), .DATA_RST(1'b0)) u_in_reg (
      .clk(clk), .rst(rst),
      .valid_i(in_valid), .ready_o(in_ready), .pg_i(ab_d), .x_i(cin),
      .valid_o(in_v), .ready_i(in_r), .pg_o(ab_q), .x_o(cin_q)
    );
  end else begin : g_in_comb
    assign ab_q     = ab_d;
    assign cin_q    = cin;
    assign in_v     = in_valid;
    assign in_ready = in_r;
  end

  pg_t  [WIDTH-1:0] pg0;
  logic [WIDTH-1:0] p0;

  // cin is folded into bit 0 so every span reaching bit 0 resolves to a true carry.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      p0[i]  = ab_q[i].p ^ ab_q[i].g;
      pg0[i] = pg_t'{p0[i], ab_q[i].p & ab_q[i].g};
    end
    pg0[0] = pg_t'{1'b0, pg0[0].g | (p0[0] & cin_q)};
  end

  assign lvl_pg[0] = pg0;
  assign lvl_x[0]  = {cin_q, p0};
  assign lvl_v[0]  = in_v;
  assign in_r      = lvl_r[0];

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    pg_t [WIDTH-1:0] nxt;

    always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
        int j;
        j = (i >= D) ? i - D : 0;
        nxt[i] = (i >= D) ? pg_combine(lvl_pg[k-1][i], lvl_pg[k-1][j]) : lvl_pg[k-1][i];
      end
    end

    if (STAGE_MASK[k-1]) begin : g_reg
      ksa_pipe_reg #(.WIDTH(WIDTH), .XW(XW), .DATA_RST(1'b0)) u_stage (
        .clk(clk), .rst(rst),
        .valid_i(lvl_v[k-1]), .ready_o(lvl_r[k-1]), .pg_i(nxt), .x_i(lvl_x[k-1]),
        .valid_o(lvl_v[k]), .ready_i(lvl_r[k]), .pg_o(lvl_pg[k]), .x_o(lvl_x[k])
      );
    end else begin : g_wire
      assign lvl_pg[k]  = nxt;
      assign lvl_x[k]   = lvl_x[k-1];
      assign lvl_v[k]   = lvl_v[k-1];
      assign lvl_r[k-1] = lvl_r[k];
    end
  end

  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_d;
  pg_t  [WIDTH-1:0] out_d;
  pg_t  [WIDTH-1:0] out_q;
  logic [OXW-1:0]   oflag_d;
  logic [OXW-1:0]   oflag_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) c[i] = lvl_pg[L][i].g;
    sum_d = lvl_x[L][WIDTH-1:0] ^ {c[WIDTH-2:0], lvl_x[L][WIDTH]};
    for (int i = 0; i < WIDTH; i++) out_d[i] = pg_t'{sum_d[i], 1'b0};
  end

`ifdef KSA_OVF_EN
  assign oflag_d = {c[WIDTH-1] ^ c[WIDTH-2], c[WIDTH-1]};
  assign ovf     = oflag_q[1];
`else
  assign oflag_d = c[WIDTH-1];
  assign ovf     = 1'b0;
`endif

  ksa_pipe_reg #(.WIDTH(WIDTH), .XW(OXW), .DATA_RST(1'b1)) u_out_reg (
    .clk(clk), .rst(rst),
    .valid_i(lvl_v[L]), .ready_o(lvl_r[L]), .pg_i(out_d), .x_i(oflag_d),
    .valid_o(out_valid), .ready_i(out_ready), .pg_o(out_q), .x_o(oflag_q)
  );

  always_comb begin
    for (int i = 0; i < WIDTH; i++) sum[i] = out_q[i].p;
  end
  assign cout = oflag_q[0];

  logic unused_bits;
  assign unused_bits = ^{lvl_pg[L], out_q};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ks_adder.sv
`default_nettype none
// Bench for pipelined_ks_adder: directed and random operands checked against an
// arithmetic reference queue (16-bit default build plus a 13-bit single-register build).
module tb_pipelined_ks_adder;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic        v13, rdy13, cin13, oval13, ordy13, cout13, ovf13;
  logic [12:0] a13, b13, sum13;

  pipelined_ks_adder #(.WIDTH(16), .STAGE_MASK(32'b0101), .IN_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_ks_adder #(.WIDTH(13), .STAGE_MASK(32'b0), .IN_REG(1'b0)) dut13 (
    .clk(clk), .rst(rst), .in_valid(v13), .in_ready(rdy13),
    .a(a13), .b(b13), .cin(cin13), .out_valid(oval13), .out_ready(ordy13),
    .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input int w, input int x, input int y, input int c);
    exp_t e;
    int   full, half, t, sx, sy, sr;
    full = 1 << w;
    half = 1 << (w - 1);
    t    = x + y + c;
    sx   = (x >= half) ? x - full : x;
    sy   = (y >= half) ? y - full : y;
    sr   = sx + sy + c;
    e.s  = 16'(t % full);
    e.co = (t >= full);
`ifdef KSA_OVF_EN
    e.ov = (sr >= half) || (sr < -half);
`else
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                      input logic c, input logic ordy, output logic got, output logic rdy);
    exp_t e;
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    @(negedge clk);
    got = out_valid;
    rdy = in_ready;
    if (out_valid && out_ready) begin
      chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(16, int'(x), int'(y), int'(c)));
    @(posedge clk);
    #1;
  endtask

  task automatic lat(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic got, rdy;
    int   n;
    step(1'b1, x, y, c, 1'b1, got, rdy);
    chk("lat_accept", 32'(rdy), 32'd1);
    n = 0;
    do begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, got, rdy);
      n++;
    end while (!got && n < 20);
    chk("latency", 32'(n), 32'(N));
  endtask

  task automatic drain();
    logic got, rdy;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, got, rdy);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        got, rdy;
    logic [15:0] hs;
    logic        hc, ho;
    logic [12:0] corner [4];
    exp_t        e;

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    v13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0; ordy13 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid13", 32'(oval13), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed carry corners
    lat(16'hFFFF, 16'h0001, 1'b0);
    lat(16'hFFFF, 16'h0001, 1'b1);
    lat(16'h7FFF, 16'h0000, 1'b1);
    lat(16'h8000, 16'h8000, 1'b0);

    // Back-to-back random stream
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, got, rdy);
      chk("stream_in_ready", 32'(rdy), 32'd1);
      if (i >= N) chk("stream_throughput", 32'(got), 32'd1);
    end
    drain();

    // Stall with out_ready low for 10 cycles
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, got, rdy);
    chk("prestall_valid", 32'(out_valid), 32'd1);
    hs = sum; hc = cout; ho = ovf;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, got, rdy);
      chk("stall_valid", 32'(got), 32'd1);
      chk("stall_sum", 32'(sum), 32'(hs));
      chk("stall_cout", 32'(cout), 32'(hc));
      chk("stall_ovf", 32'(ovf), 32'(ho));
    end
    chk("stall_in_ready", 32'(rdy), 32'd0);
    chk("stall_held", 32'(exp_q.size()), 32'(N));
    drain();

    // Reset with three results in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, got, rdy);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, got, rdy);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, got, rdy);
      chk("no_stale", 32'(got), 32'd0);
    end
    lat(16'h1234, 16'h4321, 1'b1);

    // 13-bit single-register build: corner sweep
    corner[0] = 13'd0; corner[1] = 13'd1; corner[2] = 13'd4096; corner[3] = 13'd8191;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < 2; k++) begin
          a13 = corner[i]; b13 = corner[j]; cin13 = 1'(k); v13 = 1'b1;
          @(negedge clk);
          chk("w13_ready", 32'(rdy13), 32'd1);
          @(posedge clk);
          #1 v13 = 1'b0;
          @(negedge clk);
          e = model(13, int'(corner[i]), int'(corner[j]), k);
          chk("w13_valid", 32'(oval13), 32'd1);
          chk("w13_sum", 32'(sum13), 32'(e.s[12:0]));
          chk("w13_cout", 32'(cout13), 32'(e.co));
          chk("w13_ovf", 32'(ovf13), 32'(e.ov));
          @(posedge clk);
          #1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
